// File: rtl/prm_rd_seq.sv
// Readout sequencer for the edge-result accumulator: walks all 128 words via sel1/sel2,
// streams each captured word on a valid/ready port and keeps a popcount of the whole mask.
module prm_rd_seq #(
  parameter int unsigned WORD_W         = 32,
  parameter int unsigned NUM_BANK       = 8,
  parameter int unsigned WORDS_PER_BANK = 16,
  parameter int unsigned CNT_W          = 13
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              start,
  input  logic              abort,
  output logic [2:0]        sel1,
  output logic [7:0]        sel2,
  input  logic [WORD_W-1:0] result_imp,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WORD_W-1:0] m_data,
  output logic [6:0]        m_index,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  hit_count
);

  localparam int unsigned LastIdx = NUM_BANK * WORDS_PER_BANK - 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCapt = 2'd1;
  localparam logic [1:0] StSend = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [6:0]        idx_q, idx_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  hit_q, hit_d;
  logic [CNT_W-1:0]  pop;
  logic              is_last;

  assign is_last = (idx_q == 7'(LastIdx));

  always_comb begin
    pop = '0;
    for (int i = 0; i < int'(WORD_W); i++) begin
      pop = pop + CNT_W'(data_q[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    hit_d   = hit_q;
    // abort wins over start and over a same-cycle handshake
    if (abort) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            idx_d   = '0;
            hit_d   = '0;
            state_d = StCapt;
          end
        end
        StCapt: begin
          data_d  = result_imp;
          state_d = StSend;
        end
        StSend: begin
          if (m_ready) begin
            hit_d = hit_q + pop;
            if (is_last) begin
              state_d = StDone;
            end else begin
              idx_d   = idx_q + 7'd1;
              state_d = StCapt;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      data_q  <= '0;
      hit_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      hit_q   <= hit_d;
    end
  end

  // Selects come straight from the index register so the accumulator mux sees clean edges.
  assign sel1      = idx_q[6:4];
  assign sel2      = {4'b0000, idx_q[3:0]};
  assign m_valid   = (state_q == StSend);
  assign m_data    = data_q;
  assign m_index   = idx_q;
  assign m_last    = m_valid && is_last;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign hit_count = hit_q;

endmodule

// File: tb/tb_prm_rd_seq.sv
// Bench for prm_rd_seq: a word-level model of the accumulator and the expected readout stream,
// checked every negedge, plus directed sweeps with hand-computed totals.
module tb_prm_rd_seq;

  logic        CLK, RST_n, start, abort, m_ready;
  logic [2:0]  sel1;
  logic [7:0]  sel2;
  logic [31:0] result_imp, m_data;
  logic [6:0]  m_index;
  logic        m_valid, m_last, busy, done;
  logic [12:0] hit_count;

  int checks = 0;
  int errors = 0;
  int word_mode = 0;
  bit chk_en = 0;

  // expected-stream model state
  bit         exp_busy, wait_cap, done_next;
  logic [6:0] exp_idx;
  int         exp_hits, hs_count;

  prm_rd_seq dut (
    .CLK(CLK), .RST_n(RST_n), .start(start), .abort(abort),
    .sel1(sel1), .sel2(sel2), .result_imp(result_imp),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index),
    .m_last(m_last), .busy(busy), .done(done), .hit_count(hit_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [31:0] model_word(input int mode, input logic [6:0] k);
    case (mode)
      0:       return {25'd0, k};
      1:       return 32'hFFFF_FFFF;
      default: return ({25'd0, k} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  assign result_imp = model_word(word_mode, {sel1, sel2[3:0]});

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    exp_busy = 0; wait_cap = 0; done_next = 0; exp_idx = '0; exp_hits = 0;
  endtask

  always @(negedge CLK) begin
    if (chk_en && RST_n) begin
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'(done_next));
      chk("hit_count", 32'(hit_count), 32'(exp_hits));
      if (exp_busy) begin
        chk("sel1", 32'(sel1), 32'(exp_idx[6:4]));
        chk("sel2", 32'(sel2), {28'd0, exp_idx[3:0]});
      end
      if (exp_busy && !done_next) begin
        chk("m_valid", 32'(m_valid), 32'(!wait_cap));
        if (!wait_cap) begin
          chk("m_data", m_data, model_word(word_mode, exp_idx));
          chk("m_index", 32'(m_index), 32'(exp_idx));
          chk("m_last", 32'(m_last), 32'(exp_idx == 7'd127));
        end
      end else begin
        chk("m_valid_off", 32'(m_valid), 32'd0);
      end
      // advance the model for the coming edge
      if (done_next) begin
        done_next = 0;
        exp_busy  = 0;
      end else if (exp_busy) begin
        if (abort) exp_busy = 0;
        else if (wait_cap) wait_cap = 0;
        else if (m_ready) begin
          hs_count++;
          exp_hits += $countones(model_word(word_mode, exp_idx));
          if (exp_idx == 7'd127) done_next = 1;
          else begin
            exp_idx  = exp_idx + 7'd1;
            wait_cap = 1;
          end
        end
      end else if (start && !abort) begin
        exp_busy = 1; wait_cap = 1; exp_idx = '0; exp_hits = 0;
      end
    end
  end

  // Entered at posedge+1; returns at posedge+1 in the DONE cycle, the first idle cycle, or on timeout.
  // rmode 0: ready held high; rmode 1: ready high one cycle in three so stalls land in SEND.
  task automatic sweep(input int rmode, input int abort_at, input int restart_at,
                       output int cycles, output int hs, output bit finished);
    int hs0;
    bit restarted;
    hs0 = hs_count; restarted = 0; finished = 0;
    m_ready = 1'b1; start = 1'b1; cycles = 1;
    for (int n = 0; n < 1500; n++) begin
      @(posedge CLK); #1;
      cycles++; start = 1'b0; abort = 1'b0;
      if (done) begin finished = 1; break; end
      if (!busy) break;
      if (rmode == 1) m_ready = (cycles % 3 == 1);
      if (abort_at >= 0 && m_valid && m_index == 7'(abort_at)) begin
        abort = 1'b1; m_ready = 1'b1;
      end
      if (!restarted && restart_at >= 0 && m_valid && m_index == 7'(restart_at)) begin
        start = 1'b1; restarted = 1;
      end
    end
    hs = hs_count - hs0;
  endtask

  int  cyc, hs;
  bit  fin;

  initial begin
    RST_n = 1'b0; start = 1'b0; abort = 1'b0; m_ready = 1'b0;
    hs_count = 0;
    reset_model();
    #3;
    chk("rst_sel1", 32'(sel1), 32'd0);
    chk("rst_sel2", 32'(sel2), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_m_data", m_data, 32'd0);
    chk("rst_hit", 32'(hit_count), 32'd0);
    #9 RST_n = 1'b1;
    @(posedge CLK); #1;
    chk_en = 1;

    // word k = k, ready high: 2 cycles/word, popcount(0..127) = 448
    word_mode = 0;
    sweep(0, -1, -1, cyc, hs, fin);
    chk("t1_finished", 32'(fin), 32'd1);
    chk("t1_cycles", 32'(cyc), 32'd258);
    chk("t1_handshakes", 32'(hs), 32'd128);
    chk("t1_hits", 32'(hit_count), 32'd448);
    chk("t1_done_valid", 32'(m_valid), 32'd0);
    chk("t1_done_index", 32'(m_index), 32'd127);
    repeat (3) @(posedge CLK);
    #1;

    // all-ones mask with stalls
    word_mode = 1;
    sweep(1, -1, -1, cyc, hs, fin);
    chk("t2_finished", 32'(fin), 32'd1);
    chk("t2_handshakes", 32'(hs), 32'd128);
    chk("t2_hits", 32'(hit_count), 32'd4096);
    repeat (2) @(posedge CLK);
    #1;

    // abort at index 37: words 0..36 counted, popcount sum = 80 + 10 = 90
    word_mode = 0;
    sweep(0, 37, -1, cyc, hs, fin);
    chk("t3_finished", 32'(fin), 32'd0);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_valid", 32'(m_valid), 32'd0);
    chk("t3_handshakes", 32'(hs), 32'd37);
    chk("t3_hits", 32'(hit_count), 32'd90);
    chk("t3_index_held", 32'(m_index), 32'd37);
    repeat (4) @(posedge CLK);
    #1;
    sweep(0, -1, -1, cyc, hs, fin);
    chk("t3r_finished", 32'(fin), 32'd1);
    chk("t3r_handshakes", 32'(hs), 32'd128);
    chk("t3r_hits", 32'(hit_count), 32'd448);
    repeat (2) @(posedge CLK);
    #1;

    // start pulsed mid-sweep is ignored
    word_mode = 2;
    sweep(0, -1, 50, cyc, hs, fin);
    chk("t4_finished", 32'(fin), 32'd1);
    chk("t4_cycles", 32'(cyc), 32'd258);
    chk("t4_handshakes", 32'(hs), 32'd128);
    repeat (2) @(posedge CLK);
    #1;

    // async reset while in CAPT, between clock edges
    start = 1'b1; m_ready = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (7) @(posedge CLK);
    #1;
    for (int n = 0; n < 4 && !(busy && !m_valid); n++) begin
      @(posedge CLK); #1;
    end
    chk("t5_in_capt", 32'(busy && !m_valid), 32'd1);
    chk_en = 0;
    #1 RST_n = 1'b0;
    #1;
    chk("t5_valid", 32'(m_valid), 32'd0);
    chk("t5_sel1", 32'(sel1), 32'd0);
    chk("t5_sel2", 32'(sel2), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_hits", 32'(hit_count), 32'd0);
    #1 RST_n = 1'b1;
    reset_model();
    chk_en = 1;
    repeat (3) @(posedge CLK);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
